dmi_req_sync: RTL and testbench
===============================

// Module: dmi_req_sync
// PURPOSE
//  Parametrised, multi-channel successor to the DMI-to-DM strobe synchroniser, sitting between the DTM/TAP and dm.
//  Brings asynchronous level requests (rd, wr, ...) into the core clock and captures address/data once per request.
//  Runs a 4-phase req/ack handshake back to the source, so transfers can no longer be lost or replayed.
//  Tracks DM completion (done_i) and returns read data held stable under ack.
// PARAMETERS
//  NUM_CH          2     number of request channels (ch0 = rd, ch1 = wr in debug_top); >=1
//  SYNC_STAGES     2     flops per req synchroniser chain; >=2
//  AW              7     DMI address width
//  DW              32    DMI data width
//  TIMEOUT_CYCLES  1024  WAIT_DONE limit, used only with DMI_SYNC_TIMEOUT_EN
// PORTS
//  clk_i      in   1                 core clock
//  rst_i      in   1                 synchronous, active-high reset
//  req_i      in   NUM_CH            async level requests, held until ack_o seen
//  addr_i     in   AW                async, stable while any req_i high
//  wdata_i    in   DW                async, stable while any req_i high
//  ack_o      out  1                 handshake ack to source (level)
//  rdata_o    out  DW                DM read data, stable while ack_o=1
//  pulse_o    out  NUM_CH            one-cycle strobe to DM, one-hot
//  addr_o     out  AW                captured address, valid from pulse_o until next capture
//  wdata_o    out  DW                captured write data, same validity as addr_o
//  done_i     in   1                 DM completion (pulse or level)
//  rdata_i    in   DW                DM read data, sampled when done_i is accepted
//  busy_o     out  1                 high in any state other than IDLE
//  collide_o  out  1                 sticky: a request edge was dropped
//  timeout_o  out  1                 sticky: DM did not complete (0 if macro absent)
//  err_clr_i  in   1                 clears collide_o and timeout_o
// BEHAVIOUR
//  - Reset: all outputs 0; sync chains, edge regs and arm bits 0; FSM=IDLE.
//  - Per channel: sync = s[SYNC_STAGES-1]; prev <= sync.
//    arm <= 1 when sync==0; arm <= 0 when the channel is accepted.
//  - rise[c] = sync & ~prev & arm. A request held high across reset is never serviced until it drops.
//  - Latency: req_i first sampled high at edge n -> pulse_o high in the cycle after edge n+SYNC_STAGES.
//    addr_o/wdata_o update at the same edge.
//  - FSM:
//    IDLE: on any rise, select the lowest index c, go to CAPTURE, and latch addr/wdata.
//    CAPTURE (1 cycle): pulse_o[c]=1. If done_i, latch rdata_i and go to ACK; else go to WAIT_DONE.
//    WAIT_DONE: on done_i, latch rdata_i into rdata_o and go to ACK.
//    ACK: ack_o=1. When sync[c]==0, go to IDLE with ack_o=0 the following cycle.
//  - done_i is ignored in IDLE and ACK.
//  - Multiple rises in the same IDLE cycle: the lowest index wins and the others set collide_o.
//  - A rise on any channel outside IDLE sets collide_o; the edge is discarded and prev still advances.
//  - err_clr_i on the same cycle as a new error: the set wins.
//  - rst_i mid-transfer: immediate return to IDLE with all outputs 0. The source sees ack_o drop and must drop req_i.
//  - Outputs pulse_o, ack_o, busy_o, rdata_o, addr_o, wdata_o are all registered.
// CONFIGURATION
//  DMI_SYNC_TIMEOUT_EN defined:
//  - A counter (clog2(TIMEOUT_CYCLES+1) bits) clears on CAPTURE entry and increments in WAIT_DONE.
//  - At TIMEOUT_CYCLES: go to ACK, rdata_o=0, set timeout_o.
//  - A done_i arriving on the timeout cycle takes priority: normal completion, no flag.
//  Undefined: no counter; WAIT_DONE waits indefinitely; timeout_o is tied to 0.
// TESTING
//  1 NUM_CH=2, SYNC_STAGES=2:
//    - Stimulus: req_i=01, addr_i=7'h10.
//    - Expected: pulse_o=01 in cycle 3 after sampling, addr_o=10h. done_i next cycle -> ack_o=1.
//    - Drop req -> ack_o=0 after 3 cycles.
//  2 Write with wdata_i=DEADBEEF:
//    - Expected: pulse_o=10 and wdata_o=DEADBEEF, exactly one pulse per req.
//    - rdata_i=CAFEF00D on a read done -> rdata_o=CAFEF00D held while ack_o=1.
//  3 Collisions:
//    - req_i=11 rising on the same edge -> pulse_o=01 only, collide_o=1.
//    - err_clr_i -> collide_o=0.
//  4 Reset and rise during busy:
//    - req_i held high through reset -> no pulse_o until req_i drops and re-rises.
//    - Rise while busy -> collide_o=1.
//  5 Reset mid-operation: rst_i in WAIT_DONE -> next cycle busy_o=0, ack_o=0, FSM=IDLE.
//  6 With DMI_SYNC_TIMEOUT_EN and TIMEOUT_CYCLES=8, no done_i:
//    - Expected: ack_o=1 at WAIT_DONE cycle 8, timeout_o=1, rdata_o=0.
//    - done_i on cycle 8 -> no flag.

Source files
------------

// File: rtl/dmi_req_sync.sv
// Purpose  : brings async DMI level requests into clk_i, captures addr/wdata once per request, 4-phase req/ack to source.
// Latency  : req_i sampled at edge n -> pulse_o/addr_o/wdata_o registered at edge n+SYNC_STAGES; ack_o follows DM done_i.
// Backpres.: one transfer in flight; source holds req_i until ack_o, rises on other channels while busy are dropped (collide_o).
//
// Ports
//   clk_i, rst_i          core clock, synchronous active-high reset
//   req_i[NUM_CH]         async level requests (ch0 = rd, ch1 = wr), held until ack_o seen
//   addr_i, wdata_i       async, stable while any req_i is high
//   ack_o                 level ack back to the source
//   rdata_o               DM read data, stable while ack_o = 1
//   pulse_o[NUM_CH]       one-cycle one-hot strobe to DM
//   addr_o, wdata_o       captured address/data, valid from pulse_o until next capture
//   done_i, rdata_i       DM completion and read data (rdata_i sampled when done_i accepted)
//   busy_o                high whenever the FSM is not IDLE
//   collide_o             sticky: a request edge was dropped
//   timeout_o             sticky: DM never completed (only with DMI_SYNC_TIMEOUT_EN)
//   err_clr_i             clears collide_o / timeout_o (a simultaneous set wins)
//
// Optional feature macro: DMI_SYNC_TIMEOUT_EN (WAIT_DONE timeout after TIMEOUT_CYCLES).

module dmi_req_sync #(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned AW             = 7,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] req_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DW-1:0]     wdata_i,
    output logic              ack_o,
    output logic [DW-1:0]     rdata_o,
    output logic [NUM_CH-1:0] pulse_o,
    output logic [AW-1:0]     addr_o,
    output logic [DW-1:0]     wdata_o,
    input  logic              done_i,
    input  logic [DW-1:0]     rdata_i,
    output logic              busy_o,
    output logic              collide_o,
    output logic              timeout_o,
    input  logic              err_clr_i
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        WAIT_DONE,
        ACK
    } state_t;

    state_t state_q;

    // Per-channel synchroniser chains, edge history and arm bits.
    logic [NUM_CH-1:0][SYNC_STAGES-1:0] chain_q;
    logic [NUM_CH-1:0]                  prev_q;
    logic [NUM_CH-1:0]                  arm_q;
    logic [NUM_CH-1:0]                  sel_q;

    // Shifts in ones after reset; its last bit says the chains now hold real
    // samples of req_i rather than their reset zeros. Without it a request
    // held across reset would look low for SYNC_STAGES cycles, arm itself and
    // be serviced.
    logic [SYNC_STAGES-1:0]             fill_q;
    logic                               chain_valid;

    logic [NUM_CH-1:0] sync;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] win_oh;
    logic              win_found;
    logic [NUM_CH-1:0] accept_oh;
    logic              collide_set;

`ifdef DMI_SYNC_TIMEOUT_EN
    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCW-1:0] tmo_cnt_q;
    logic [TCW-1:0] tmo_cnt_nxt;
`endif

    assign chain_valid = fill_q[SYNC_STAGES-1];

    always_comb begin
        sync      = '0;
        win_oh    = '0;
        win_found = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            sync[c] = chain_q[c][SYNC_STAGES-1];
        end
        rise = sync & ~prev_q & arm_q;
        // Fixed priority: lowest channel index wins.
        for (int c = 0; c < NUM_CH; c++) begin
            if (rise[c] && !win_found) begin
                win_oh[c] = 1'b1;
                win_found = 1'b1;
            end
        end
        accept_oh = (state_q == IDLE) ? win_oh : '0;
        // In IDLE only the losers of the arbitration collide; elsewhere every
        // rise is dropped.
        collide_set = (state_q == IDLE) ? |(rise & ~win_oh) : |rise;
    end

`ifdef DMI_SYNC_TIMEOUT_EN
    assign tmo_cnt_nxt = tmo_cnt_q + 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            chain_q   <= '0;
            prev_q    <= '0;
            arm_q     <= '0;
            sel_q     <= '0;
            fill_q    <= '0;
            ack_o     <= 1'b0;
            rdata_o   <= '0;
            pulse_o   <= '0;
            addr_o    <= '0;
            wdata_o   <= '0;
            busy_o    <= 1'b0;
            collide_o <= 1'b0;
`ifdef DMI_SYNC_TIMEOUT_EN
            tmo_cnt_q <= '0;
            timeout_o <= 1'b0;
`endif
        end else begin
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            for (int c = 0; c < NUM_CH; c++) begin
                chain_q[c] <= {chain_q[c][SYNC_STAGES-2:0], req_i[c]};
            end
            // History always advances, so a discarded edge is gone for good.
            prev_q <= sync;
            arm_q  <= (arm_q | ({NUM_CH{chain_valid}} & ~sync)) & ~accept_oh;

            pulse_o   <= '0;
            collide_o <= collide_set | (collide_o & ~err_clr_i);
`ifdef DMI_SYNC_TIMEOUT_EN
            timeout_o <= timeout_o & ~err_clr_i;
`endif

            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q <= CAPTURE;
                        sel_q   <= win_oh;
                        pulse_o <= win_oh;
                        addr_o  <= addr_i;
                        wdata_o <= wdata_i;
                        busy_o  <= 1'b1;
`ifdef DMI_SYNC_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end

                CAPTURE: begin
                    if (done_i) begin
                        rdata_o <= rdata_i;
                        ack_o   <= 1'b1;
                        state_q <= ACK;
                    end else begin
                        state_q <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (done_i) begin
                        rdata_o <= rdata_i;
                        ack_o   <= 1'b1;
                        state_q <= ACK;
                    end
`ifdef DMI_SYNC_TIMEOUT_EN
                    // Completion beats the timeout when both land together.
                    else if (tmo_cnt_nxt == TCW'(TIMEOUT_CYCLES)) begin
                        rdata_o   <= '0;
                        ack_o     <= 1'b1;
                        timeout_o <= 1'b1;
                        state_q   <= ACK;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_nxt;
                    end
`endif
                end

                ACK: begin
                    // Hold ack until the serviced channel's request is seen low.
                    if ((sync & sel_q) == '0) begin
                        ack_o   <= 1'b0;
                        busy_o  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifndef DMI_SYNC_TIMEOUT_EN
    // No completion watchdog in this build; WAIT_DONE waits for done_i forever.
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmi_req_sync.sv
// Purpose  : self-checking bench for dmi_req_sync, table-driven vectors plus multi-cycle corner sequences.
// Latency  : checks pulse_o SYNC_STAGES edges after req_i is sampled, ack_o drop 3 edges after req_i falls.
// Backpres.: exercises collisions while busy, reset mid-transfer and the optional WAIT_DONE timeout.

module tb_dmi_req_sync;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata_o;
    logic [1:0]  pulse;
    logic [6:0]  addr_o;
    logic [31:0] wdata_o;
    logic        done;
    logic [31:0] rdata_i;
    logic        busy;
    logic        collide;
    logic        timeout;
    logic        err_clr;

    int n_chk  = 0;
    int n_fail = 0;

    dmi_req_sync #(
        .NUM_CH        (2),
        .SYNC_STAGES   (2),
        .AW            (7),
        .DW            (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .ack_o    (ack),
        .rdata_o  (rdata_o),
        .pulse_o  (pulse),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .done_i   (done),
        .rdata_i  (rdata_i),
        .busy_o   (busy),
        .collide_o(collide),
        .timeout_o(timeout),
        .err_clr_i(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic        done;
        logic [31:0] rdata;
        logic        clr;
        logic        e_ack;
        logic [1:0]  e_pulse;
        logic [6:0]  e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_busy;
        logic        e_col;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [1:0] q, input logic [6:0] a, input logic [31:0] wd,
                       input logic d, input logic [31:0] rd, input logic c,
                       input logic e_ack, input logic [1:0] e_pulse, input logic [6:0] e_addr,
                       input logic [31:0] e_wdata, input logic [31:0] e_rdata, input logic e_busy,
                       input logic e_col);
        vec_t v;
        v.rst = r; v.req = q; v.addr = a; v.wdata = wd; v.done = d; v.rdata = rd; v.clr = c;
        v.e_ack = e_ack; v.e_pulse = e_pulse; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_rdata = e_rdata; v.e_busy = e_busy; v.e_col = e_col;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
        end
        chk({name, "_idle_reached"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic seen;
        rst = 1'b1; req = '0; addr = '0; wdata = '0; done = 1'b0; rdata_i = '0; err_clr = 1'b0;

        //   rst req  addr   wdata         done rdata         clr | ack pulse addr_o wdata_o       rdata_o       busy col
        add(1, 2'b00, 7'h00, 32'h0,        0, 32'h0,        0,   0, 2'b00, 7'h00, 32'h0,        32'h0,        0, 0);
        add(0, 2'b00, 7'h00, 32'h0,        0, 32'h0,        0,   0, 2'b00, 7'h00, 32'h0,        32'h0,        0, 0);
        add(0, 2'b00, 7'h00, 32'h0,        0, 32'h0,        0,   0, 2'b00, 7'h00, 32'h0,        32'h0,        0, 0);
        add(0, 2'b00, 7'h00, 32'h0,        0, 32'h0,        0,   0, 2'b00, 7'h00, 32'h0,        32'h0,        0, 0);
        // read on ch0: pulse on the third edge, done in CAPTURE
        add(0, 2'b01, 7'h10, 32'h0,        0, 32'h0,        0,   0, 2'b00, 7'h00, 32'h0,        32'h0,        0, 0);
        add(0, 2'b01, 7'h10, 32'h0,        0, 32'h0,        0,   0, 2'b00, 7'h00, 32'h0,        32'h0,        0, 0);
        add(0, 2'b01, 7'h10, 32'h0,        0, 32'h0,        0,   0, 2'b01, 7'h10, 32'h0,        32'h0,        1, 0);
        add(0, 2'b01, 7'h10, 32'h0,        1, 32'hCAFEF00D, 0,   1, 2'b00, 7'h10, 32'h0,        32'hCAFEF00D, 1, 0);
        add(0, 2'b01, 7'h10, 32'h0,        0, 32'h0,        0,   1, 2'b00, 7'h10, 32'h0,        32'hCAFEF00D, 1, 0);
        add(0, 2'b00, 7'h10, 32'h0,        0, 32'h0,        0,   1, 2'b00, 7'h10, 32'h0,        32'hCAFEF00D, 1, 0);
        add(0, 2'b00, 7'h10, 32'h0,        0, 32'h0,        0,   1, 2'b00, 7'h10, 32'h0,        32'hCAFEF00D, 1, 0);
        add(0, 2'b00, 7'h10, 32'h0,        0, 32'h0,        0,   0, 2'b00, 7'h10, 32'h0,        32'hCAFEF00D, 0, 0);
        // write on ch1: single pulse, two WAIT_DONE cycles
        add(0, 2'b10, 7'h05, 32'hDEADBEEF, 0, 32'h0,        0,   0, 2'b00, 7'h10, 32'h0,        32'hCAFEF00D, 0, 0);
        add(0, 2'b10, 7'h05, 32'hDEADBEEF, 0, 32'h0,        0,   0, 2'b00, 7'h10, 32'h0,        32'hCAFEF00D, 0, 0);
        add(0, 2'b10, 7'h05, 32'hDEADBEEF, 0, 32'h0,        0,   0, 2'b10, 7'h05, 32'hDEADBEEF, 32'hCAFEF00D, 1, 0);
        add(0, 2'b10, 7'h05, 32'hDEADBEEF, 0, 32'h0,        0,   0, 2'b00, 7'h05, 32'hDEADBEEF, 32'hCAFEF00D, 1, 0);
        add(0, 2'b10, 7'h05, 32'hDEADBEEF, 0, 32'h0,        0,   0, 2'b00, 7'h05, 32'hDEADBEEF, 32'hCAFEF00D, 1, 0);
        add(0, 2'b10, 7'h05, 32'hDEADBEEF, 1, 32'h12345678, 0,   1, 2'b00, 7'h05, 32'hDEADBEEF, 32'h12345678, 1, 0);
        add(0, 2'b00, 7'h05, 32'hDEADBEEF, 0, 32'h0,        0,   1, 2'b00, 7'h05, 32'hDEADBEEF, 32'h12345678, 1, 0);
        add(0, 2'b00, 7'h05, 32'hDEADBEEF, 0, 32'h0,        0,   1, 2'b00, 7'h05, 32'hDEADBEEF, 32'h12345678, 1, 0);
        add(0, 2'b00, 7'h05, 32'hDEADBEEF, 0, 32'h0,        0,   0, 2'b00, 7'h05, 32'hDEADBEEF, 32'h12345678, 0, 0);
        // both channels rise together: ch0 wins, collide set, then cleared
        add(0, 2'b11, 7'h22, 32'h0,        0, 32'h0,        0,   0, 2'b00, 7'h05, 32'hDEADBEEF, 32'h12345678, 0, 0);
        add(0, 2'b11, 7'h22, 32'h0,        0, 32'h0,        0,   0, 2'b00, 7'h05, 32'hDEADBEEF, 32'h12345678, 0, 0);
        add(0, 2'b11, 7'h22, 32'h0,        0, 32'h0,        0,   0, 2'b01, 7'h22, 32'h0,        32'h12345678, 1, 1);
        add(0, 2'b11, 7'h22, 32'h0,        1, 32'h0,        0,   1, 2'b00, 7'h22, 32'h0,        32'h0,        1, 1);
        add(0, 2'b00, 7'h22, 32'h0,        0, 32'h0,        0,   1, 2'b00, 7'h22, 32'h0,        32'h0,        1, 1);
        add(0, 2'b00, 7'h22, 32'h0,        0, 32'h0,        0,   1, 2'b00, 7'h22, 32'h0,        32'h0,        1, 1);
        add(0, 2'b00, 7'h22, 32'h0,        0, 32'h0,        0,   0, 2'b00, 7'h22, 32'h0,        32'h0,        0, 1);
        add(0, 2'b00, 7'h22, 32'h0,        0, 32'h0,        1,   0, 2'b00, 7'h22, 32'h0,        32'h0,        0, 0);
        add(0, 2'b00, 7'h22, 32'h0,        0, 32'h0,        0,   0, 2'b00, 7'h22, 32'h0,        32'h0,        0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; req = tbl[i].req; addr = tbl[i].addr; wdata = tbl[i].wdata;
            done = tbl[i].done; rdata_i = tbl[i].rdata; err_clr = tbl[i].clr;
            tick();
            chk($sformatf("row%0d_ack", i),     {31'd0, ack},     {31'd0, tbl[i].e_ack});
            chk($sformatf("row%0d_pulse", i),   {30'd0, pulse},   {30'd0, tbl[i].e_pulse});
            chk($sformatf("row%0d_addr", i),    {25'd0, addr_o},  {25'd0, tbl[i].e_addr});
            chk($sformatf("row%0d_wdata", i),   wdata_o,          tbl[i].e_wdata);
            chk($sformatf("row%0d_rdata", i),   rdata_o,          tbl[i].e_rdata);
            chk($sformatf("row%0d_busy", i),    {31'd0, busy},    {31'd0, tbl[i].e_busy});
            chk($sformatf("row%0d_collide", i), {31'd0, collide}, {31'd0, tbl[i].e_col});
            chk($sformatf("row%0d_timeout", i), {31'd0, timeout}, 32'd0);
        end
        done = 1'b0; err_clr = 1'b0;

        // Request held high through reset is ignored until it drops and re-rises.
        rst = 1'b1; req = 2'b01; addr = 7'h33;
        ticks(3);
        chk("rst_addr_cleared", {25'd0, addr_o}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pulse != 2'b00 || busy) seen = 1'b1;
        end
        chk("held_req_no_pulse", {31'd0, seen}, 32'd0);
        req = 2'b00;
        ticks(4);
        req = 2'b01;
        ticks(2);
        chk("rerise_pulse_early", {30'd0, pulse}, 32'd0);
        tick();
        chk("rerise_pulse", {30'd0, pulse}, 32'd1);
        chk("rerise_addr", {25'd0, addr_o}, 32'h33);
        done = 1'b1; rdata_i = 32'hA5A5A5A5;
        tick();
        done = 1'b0;
        chk("rerise_ack", {31'd0, ack}, 32'd1);
        req = 2'b00;
        wait_idle("rerise");

        // Rise on ch1 while busy: dropped, collide set even with err_clr on the same edge.
        tick();
        req = 2'b01;
        ticks(3);
        chk("busy_pulse", {30'd0, pulse}, 32'd1);
        tick();
        chk("busy_wait", {31'd0, busy}, 32'd1);
        req = 2'b11;
        ticks(2);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("busy_collide_setwins", {31'd0, collide}, 32'd1);
        chk("busy_no_ch1_pulse", {30'd0, pulse}, 32'd0);
        chk("busy_no_ack", {31'd0, ack}, 32'd0);
        done = 1'b1; rdata_i = 32'h55AA55AA;
        tick();
        done = 1'b0;
        chk("busy_ack", {31'd0, ack}, 32'd1);
        chk("busy_rdata", rdata_o, 32'h55AA55AA);
        req = 2'b00;
        wait_idle("busy");
        chk("busy_collide_sticky", {31'd0, collide}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("busy_collide_clr", {31'd0, collide}, 32'd0);

        // Reset while in WAIT_DONE.
        ticks(2);
        req = 2'b01; addr = 7'h44;
        ticks(3);
        chk("mid_pulse", {30'd0, pulse}, 32'd1);
        chk("mid_addr", {25'd0, addr_o}, 32'h44);
        tick();
        chk("mid_wait_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ack", {31'd0, ack}, 32'd0);
        chk("mid_rst_addr", {25'd0, addr_o}, 32'd0);
        chk("mid_rst_rdata", rdata_o, 32'd0);
        rst = 1'b0; req = 2'b00;
        ticks(4);

`ifdef DMI_SYNC_TIMEOUT_EN
        // done_i on the eighth WAIT_DONE cycle: normal completion.
        req = 2'b01;
        ticks(3);
        chk("tmo_done_pulse", {30'd0, pulse}, 32'd1);
        ticks(8);
        chk("tmo_done_pre_ack", {31'd0, ack}, 32'd0);
        done = 1'b1; rdata_i = 32'hABCD1234;
        tick();
        done = 1'b0;
        chk("tmo_done_ack", {31'd0, ack}, 32'd1);
        chk("tmo_done_noflag", {31'd0, timeout}, 32'd0);
        chk("tmo_done_rdata", rdata_o, 32'hABCD1234);
        req = 2'b00;
        wait_idle("tmo_done");
        // No done_i: ack after the eighth WAIT_DONE cycle with rdata_o = 0.
        req = 2'b01;
        ticks(3);
        chk("tmo_pulse", {30'd0, pulse}, 32'd1);
        ticks(8);
        chk("tmo_pre_ack", {31'd0, ack}, 32'd0);
        tick();
        chk("tmo_ack", {31'd0, ack}, 32'd1);
        chk("tmo_flag", {31'd0, timeout}, 32'd1);
        chk("tmo_rdata", rdata_o, 32'd0);
        req = 2'b00;
        wait_idle("tmo");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tmo_clr", {31'd0, timeout}, 32'd0);
`else
        // No watchdog: WAIT_DONE holds indefinitely and timeout_o stays 0.
        req = 2'b01;
        ticks(3);
        chk("nowd_pulse", {30'd0, pulse}, 32'd1);
        ticks(21);
        chk("nowd_still_busy", {31'd0, busy}, 32'd1);
        chk("nowd_no_ack", {31'd0, ack}, 32'd0);
        chk("nowd_no_flag", {31'd0, timeout}, 32'd0);
        done = 1'b1; rdata_i = 32'hABCD1234;
        tick();
        done = 1'b0;
        chk("nowd_ack", {31'd0, ack}, 32'd1);
        chk("nowd_rdata", rdata_o, 32'hABCD1234);
        req = 2'b00;
        wait_idle("nowd");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
